// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for the Pong datapath: IDLE -> SERVE -> PLAY -> OVER.
// Gates/reloads the ball engine, counts paddle hits as score and tracks lives.
module pong_game_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LIVES_W      = 2,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned MISS_Y       = 470,
    parameter int unsigned START_X      = 312,
    parameter int unsigned START_Y      = 232
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_frame,
    input  logic               btn_start,
    input  logic               paddle_hit,
    input  logic [8:0]         ball_y,
    output logic               ball_run,
    output logic               ball_load,
    output logic [9:0]         load_x,
    output logic [8:0]         load_y,
    output logic               load_dir_x,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         state,
    output logic               game_over
);

    // A serve length of zero is treated as a one-frame serve.
    localparam int unsigned SERVE_LOAD = (SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES;
    localparam int unsigned CNT_W      = $clog2(SERVE_LOAD + 1);

    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_LOAD);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_L  = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_1  = LIVES_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_1  = SCORE_W'(1);
    localparam logic [8:0]         MISS_Y_L = 9'(MISS_Y);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               load_q, load_d;
    logic               run_q, over_q;
    logic               btn_q;
    logic               start_edge;

    assign start_edge = btn_start & ~btn_q;

    // Next-state and datapath updates for the game sequencer.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        load_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    score_d = '0;
                    lives_d = LIVES_L;
                    cnt_d   = CNT_LOAD;
                    load_d  = 1'b1;
                    dir_d   = ~dir_q;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (new_frame) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (paddle_hit && (score_q != '1)) begin
                    score_d = score_q + SCORE_1;
                end
                if (new_frame && (ball_y >= MISS_Y_L)) begin
                    if (lives_q == LIVES_1) begin
                        lives_d = '0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_1;
                        cnt_d   = CNT_LOAD;
                        load_d  = 1'b1;
                        dir_d   = ~dir_q;
                        state_d = S_SERVE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything including any pending load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            score_q <= '0;
            lives_q <= LIVES_L;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            load_q  <= 1'b0;
            run_q   <= 1'b0;
            over_q  <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            run_q   <= (state_d == S_PLAY);
            over_q  <= (state_d == S_OVER);
            btn_q   <= btn_start;
        end
    end

    assign ball_run   = run_q;
    assign ball_load  = load_q;
    assign load_x     = 10'(START_X);
    assign load_y     = 9'(START_Y);
    assign load_dir_x = dir_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table for reset/idle/start,
// hand-written sequences for serve timing, saturation, misses and game over.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       new_frame = 1'b0;
    logic       btn_start = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [8:0] ball_y = 9'd0;
    logic       ball_run, ball_load, load_dir_x, game_over;
    logic [9:0] load_x;
    logic [8:0] load_y;
    logic [7:0] score;
    logic [1:0] lives, state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    pong_game_ctrl #(
        .SERVE_FRAMES(60),
        .LIVES       (3),
        .LIVES_W     (2),
        .SCORE_W     (8),
        .MISS_Y      (470),
        .START_X     (312),
        .START_Y     (232)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .new_frame (new_frame),
        .btn_start (btn_start),
        .paddle_hit(paddle_hit),
        .ball_y    (ball_y),
        .ball_run  (ball_run),
        .ball_load (ball_load),
        .load_x    (load_x),
        .load_y    (load_y),
        .load_dir_x(load_dir_x),
        .score     (score),
        .lives     (lives),
        .state     (state),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Expected output word: {state, score, lives, run, load, dir, over}
    function automatic logic [15:0] E(input logic [1:0] st, input int sc, input int lv,
                                      input logic run, input logic ld, input logic dir,
                                      input logic ov);
        logic [7:0] s8;
        logic [1:0] l2;
        s8 = 8'(sc);
        l2 = 2'(lv);
        return {st, s8, l2, run, ld, dir, ov};
    endfunction

    task automatic check_out();
        logic [15:0] act, exp;
        string nm;
        act = {state, score, lives, ball_run, ball_load, load_dir_x, game_over};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %h required an expected entry", act);
        end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s got st=%0d sc=%0d lv=%0d run=%b ld=%b dir=%b ov=%b required st=%0d sc=%0d lv=%0d run=%b ld=%b dir=%b ov=%b",
                         nm, act[15:14], act[13:6], act[5:4], act[3], act[2], act[1], act[0],
                         exp[15:14], exp[13:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic step(input string nm, input logic rn, input logic nf, input logic b,
                        input logic h, input logic [8:0] y, input logic [15:0] e);
        reset_n    = rn;
        new_frame  = nf;
        btn_start  = b;
        paddle_hit = h;
        ball_y     = y;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Runs a full serve: 60 strobes with quiet cycles between; hits and button
    // activity during the serve must have no effect.
    task automatic serve(input int sc, input int lv, input logic dir, input bit held);
        logic b, h;
        for (int i = 1; i <= 60; i++) begin
            b = held ? (i <= 3) : ((i % 3) == 0);
            h = 1'(i % 2);
            if (i < 60) begin
                step("serve_count", 1'b1, 1'b1, b, h, 9'd480, E(2'd1, sc, lv, 1'b0, 1'b0, dir, 1'b0));
                step("serve_quiet", 1'b1, 1'b0, 1'b0, 1'b1, 9'd480, E(2'd1, sc, lv, 1'b0, 1'b0, dir, 1'b0));
            end else begin
                step("serve_to_play", 1'b1, 1'b1, 1'b0, h, 9'd100, E(2'd2, sc, lv, 1'b1, 1'b0, dir, 1'b0));
            end
        end
    endtask

    typedef struct {
        logic        rn, nf, btn, hit;
        logic [8:0]  y;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        // Reset, idle frames (stray hits / low ball ignored), then start edge.
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   E(2'd0, 0, 3, 0, 0, 0, 0)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 9'd0,   E(2'd0, 0, 3, 0, 0, 0, 0)});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 9'd470, E(2'd0, 0, 3, 0, 0, 0, 0)});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 9'd0,   E(2'd1, 0, 3, 0, 1, 1, 0)});

        for (int i = 0; i < vecs.size(); i++)
            step("table", vecs[i].rn, vecs[i].nf, vecs[i].btn, vecs[i].hit, vecs[i].y, vecs[i].exp);

        // Button held for the first 3 frames of the serve: still one load pulse.
        serve(0, 3, 1'b1, 1'b1);

        for (int i = 1; i <= 5; i++)
            step("play_hit", 1'b1, 1'b0, 1'b0, 1'b1, 9'd100, E(2'd2, i, 3, 1, 0, 1, 0));
        step("miss_469", 1'b1, 1'b1, 1'b0, 1'b0, 9'd469, E(2'd2, 5, 3, 1, 0, 1, 0));
        step("no_frame_470", 1'b1, 1'b0, 1'b0, 1'b0, 9'd470, E(2'd2, 5, 3, 1, 0, 1, 0));
        step("hit_and_miss", 1'b1, 1'b1, 1'b0, 1'b1, 9'd470, E(2'd1, 6, 2, 0, 1, 0, 0));

        serve(6, 2, 1'b0, 1'b0);

        for (int i = 1; i <= 300; i++) begin
            sc = (6 + i > 255) ? 255 : 6 + i;
            step("saturate", 1'b1, 1'((i % 50) == 0), 1'b0, 1'b1, 9'd100, E(2'd2, sc, 2, 1, 0, 0, 0));
        end
        step("miss_two", 1'b1, 1'b1, 1'b0, 1'b0, 9'd500, E(2'd1, 255, 1, 0, 1, 1, 0));

        serve(255, 1, 1'b1, 1'b0);

        step("last_miss", 1'b1, 1'b1, 1'b0, 1'b0, 9'd470, E(2'd3, 255, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            step("over_hold", 1'b1, 1'b1, 1'b0, 1'b1, 9'd470, E(2'd3, 255, 0, 0, 0, 1, 1));
        step("restart", 1'b1, 1'b0, 1'b1, 1'b0, 9'd0, E(2'd1, 0, 3, 0, 1, 0, 0));
        step("restart_frame", 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, E(2'd1, 0, 3, 0, 0, 0, 0));
        step("reset_mid_serve", 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, E(2'd0, 0, 3, 0, 0, 0, 0));
        step("after_reset", 1'b1, 1'b1, 1'b0, 1'b1, 9'd470, E(2'd0, 0, 3, 0, 0, 0, 0));

        checks++;
        if (load_x !== 10'd312 || load_y !== 9'd232) begin
            errors++;
            $display("FAIL load_xy got %0d/%0d required 312/232", load_x, load_y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
